// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg: shared configuration and types for the fetch stage.
//   XLEN             - instruction / address word width (32).
//   DEFAULT_DEPTH    - default instruction-queue depth.
//   DEFAULT_RESET_PC - default fetch address after reset.
//   fetch_state_e    - memory-handshake FSM states.
//   fetch_entry_t    - one queue entry: {pc, inst}.
//   word_align()     - clears the byte-offset bits of an address.
package inst_fetcher_pkg;

  localparam int              XLEN             = 32;
  localparam int              DEFAULT_DEPTH    = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,  // no request outstanding
    S_WAIT    = 2'd1,  // request outstanding, its data will be queued
    S_DISCARD = 2'd2   // request outstanding, its data is stale (jump seen)
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// inst_queue: circular FIFO of {pc, inst} entries between fetch and issue.
//   clk, rst    - clock and asynchronous active-low reset.
//   push        - write push_entry at the tail.
//   pop         - drop the head entry.
//   flush       - empty the queue; overrides push and pop in the same cycle.
//   push_entry  - entry to write.
//   head_entry  - combinational read of the head (zero while empty).
//   count       - number of valid entries (0..DEPTH).
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     storage [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !flush;
  assign pop_ok  = pop && !flush && (count_reg != '0);

  // Storage carries no reset; emptiness is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      storage[tail_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) tail_reg <= tail_reg + 1'b1;
      if (pop_ok)  head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Stale storage is never shown: an empty queue presents zeros.
  assign head_entry = (count_reg != '0) ? storage[head_reg] : '0;
  assign count      = count_reg;

endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: fetch stage. Requests aligned words from memory with a
// single outstanding request, queues {pc, inst} pairs and presents the
// queue head to Issue. Redirects on jump_enable; prediction is pc+4.
//   clk, rst       - clock and asynchronous active-low reset.
//   rdy            - global ready; all state holds while low.
//   jump_enable    - redirect and flush strobe.
//   jump_pc        - redirect target (byte offset bits ignored).
//   issue_stall    - Issue cannot take the head this cycle.
//   inst_valid     - queue head valid.
//   inst_to_issue  - head instruction word.
//   pc_to_issue    - head pc.
//   mem_req        - registered fetch request.
//   mem_addr       - registered, word-aligned fetch address.
//   mem_done       - one-cycle strobe: mem_data answers the current request.
//   mem_data       - fetched word.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int              DEPTH    = DEFAULT_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            jump_enable,
  input  logic [XLEN-1:0] jump_pc,
  input  logic            issue_stall,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_to_issue,
  output logic [XLEN-1:0] pc_to_issue,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_done,
  input  logic [XLEN-1:0] mem_data
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] mem_addr_reg, mem_addr_next;
  logic            mem_req_reg, mem_req_next;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;
  logic             flush;
  logic             has_space;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign inst_valid = (count != '0);
  assign flush      = rdy && jump_enable;
  assign pop        = rdy && inst_valid && !issue_stall && !jump_enable;
  assign push       = rdy && !jump_enable && (state_reg == S_WAIT) && mem_done;
  assign push_entry = '{pc: fetch_pc_reg, inst: mem_data};

  // Occupancy after this cycle's push/pop. A request is only launched when
  // this leaves a free slot, so the returning word can always be queued.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign has_space = (count_next < CNT_W'(DEPTH));

  inst_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (count)
  );

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    if (rdy) begin
      if (jump_enable) begin
        fetch_pc_next = word_align(jump_pc);
        case (state_reg)
          S_IDLE: state_next = S_IDLE;
          S_WAIT, S_DISCARD: begin
            // The in-flight word is stale. If it lands this very cycle the
            // request is over; otherwise keep mem_req up and drop it later.
            if (mem_done) begin
              mem_req_next = 1'b0;
              state_next   = S_IDLE;
            end else begin
              state_next = S_DISCARD;
            end
          end
          default: state_next = S_IDLE;
        endcase
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (has_space) begin
              mem_req_next  = 1'b1;
              mem_addr_next = fetch_pc_reg;
              state_next    = S_WAIT;
            end
          end
          S_WAIT: begin
            if (mem_done) begin
              fetch_pc_next = fetch_pc_reg + 32'd4;
              if (has_space) begin
                // Back-to-back: next request goes out with the push.
                mem_addr_next = fetch_pc_reg + 32'd4;
              end else begin
                mem_req_next = 1'b0;
                state_next   = S_IDLE;
              end
            end
          end
          S_DISCARD: begin
            if (mem_done) begin
              mem_req_next = 1'b0;
              state_next   = S_IDLE;
            end
          end
          default: state_next = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= word_align(RESET_PC);
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  assign mem_req       = mem_req_reg;
  assign mem_addr      = mem_addr_reg;
  assign inst_to_issue = head_entry.inst;
  assign pc_to_issue   = head_entry.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: self-checking bench for inst_fetcher.
// The stimulus side keeps a queue of the {pc, inst} pairs Issue must see
// next (sequential pcs from the last reset/jump target, words from a fixed
// memory function); a separate monitor pops and compares on every
// consumption, and also checks the request handshake and rdy freezing.
module tb_inst_fetcher;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        jump_enable = 1'b0;
  logic [31:0] jump_pc = 32'h0;
  logic        issue_stall = 1'b0;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_to_issue;
  logic [31:0] pc_to_issue;
  logic        mem_req;
  logic [31:0] mem_addr;

  int checks = 0;
  int errors = 0;

  // memory responder knobs/state
  int          lat_max   = 0;
  int          cur_lat   = 0;
  int          wait_cnt  = 0;
  int          budget    = -1;   // deliveries still allowed; negative = unlimited
  int          delivered = 0;
  logic        ovr_en    = 1'b0;
  logic [31:0] ovr_data  = 32'h0;

  // scoreboard
  logic [63:0] exp_q[$];
  logic [31:0] exp_tail_pc = 32'h0;

  always #5 clk = ~clk;

  inst_fetcher #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .jump_enable   (jump_enable),
    .jump_pc       (jump_pc),
    .issue_stall   (issue_stall),
    .inst_valid    (inst_valid),
    .inst_to_issue (inst_to_issue),
    .pc_to_issue   (pc_to_issue),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_done      (mem_done),
    .mem_data      (mem_data)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_tail_pc = {pc[31:2], 2'b00};
  endtask

  // One clock of stimulus, driven on the falling edge, then the memory model.
  task cycle(input logic r, input logic j, input logic [31:0] jp, input logic st);
    @(negedge clk);
    rdy         = r;
    jump_enable = j;
    jump_pc     = jp;
    issue_stall = st;
    if (r && j) sb_restart(jp);
    while (exp_q.size() < 16) begin
      exp_q.push_back({exp_tail_pc, mem_word(exp_tail_pc)});
      exp_tail_pc = exp_tail_pc + 32'd4;
    end
    mem_done = 1'b0;
    if (r && rst && mem_req) begin
      if (wait_cnt >= cur_lat && budget != 0) begin
        mem_done  = 1'b1;
        mem_data  = ovr_en ? ovr_data : mem_word(mem_addr);
        ovr_en    = 1'b0;
        delivered++;
        if (budget > 0) budget--;
        wait_cnt  = 0;
        cur_lat   = int'($urandom_range(lat_max, 0));
      end else begin
        wait_cnt++;
      end
    end
  endtask

  // Asserts reset now (asynchronously), checks cleared outputs, releases it.
  task do_reset();
    rst         = 1'b0;
    rdy         = 1'b0;
    jump_enable = 1'b0;
    issue_stall = 1'b0;
    mem_done    = 1'b0;
    #1;
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst", inst_to_issue, 32'h0);
    check("rst_pc", pc_to_issue, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    wait_cnt  = 0;
    cur_lat   = 0;
    budget    = -1;
    delivered = 0;
    ovr_en    = 1'b0;
    sb_restart(RESET_PC);
    rst = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every consumption, checks the handshake.
  initial begin
    logic [63:0] e;
    logic        p_rst, p_rdy, p_req, p_done, p_valid;
    logic [31:0] p_addr, p_pc, p_inst;
    p_rst = 0; p_rdy = 0; p_req = 0; p_done = 0; p_valid = 0;
    p_addr = 0; p_pc = 0; p_inst = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst && p_rst) begin
        if (!p_rdy) begin
          check("frz_mem_req", {31'b0, mem_req}, {31'b0, p_req});
          check("frz_mem_addr", mem_addr, p_addr);
          check("frz_valid", {31'b0, inst_valid}, {31'b0, p_valid});
          check("frz_pc", pc_to_issue, p_pc);
          check("frz_inst", inst_to_issue, p_inst);
        end else if (p_req && !p_done) begin
          check("hold_mem_req", {31'b0, mem_req}, 32'h1);
          check("hold_mem_addr", mem_addr, p_addr);
        end
        if (mem_req) check("addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
      end
      if (rst && rdy && inst_valid && !issue_stall && !jump_enable) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %h with no expected entry", pc_to_issue);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", pc_to_issue, e[63:32]);
          check("pop_inst", inst_to_issue, e[31:0]);
        end
      end
      p_rst   = rst;
      p_rdy   = rdy;
      p_req   = mem_req;
      p_done  = mem_done;
      p_addr  = mem_addr;
      p_valid = inst_valid;
      p_pc    = pc_to_issue;
      p_inst  = inst_to_issue;
    end
  end

  initial begin
    int gaps;
    logic r, j, st;
    // --- reset, sequential stream with 1-cycle memory
    do_reset();
    lat_max = 0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    #3;
    check("first_req", {31'b0, mem_req}, 32'h1);
    check("first_addr", mem_addr, RESET_PC);
    for (int k = 1; k <= 5; k++) begin
      cycle(1, 0, 0, 0);
      #1;
      check("seq_addr", mem_addr, RESET_PC + 32'(4 * k));
    end
    gaps = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, 0, 0, 0);
      #1;
      if (!inst_valid) gaps++;
    end
    check("valid_gaps", 32'(gaps), 32'h0);
    $display("stream: seq fetch done, %0d words delivered", delivered);

    // --- stall until full: exactly DEPTH requests
    do_reset();
    repeat (12) cycle(1, 0, 0, 1);
    #3;
    check("full_requests", 32'(delivered), 32'(DEPTH));
    check("full_mem_req", {31'b0, mem_req}, 32'h0);
    check("full_head_pc", pc_to_issue, RESET_PC);
    check("full_valid", {31'b0, inst_valid}, 32'h1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    #3;
    check("resume_req", {31'b0, mem_req}, 32'h1);
    check("resume_addr", mem_addr, RESET_PC + 32'h10);
    repeat (10) cycle(1, 0, 0, 0);
    $display("stall: full queue and resume done");

    // --- jump with request outstanding, stale word arrives later
    do_reset();
    budget = 2;
    repeat (6) cycle(1, 0, 0, 1);
    #3;
    check("pend_addr", mem_addr, 32'h8);
    cycle(1, 1, 32'h100, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    #3;
    check("disc_valid", {31'b0, inst_valid}, 32'h0);
    check("disc_addr", mem_addr, 32'h8);
    budget   = 1;
    ovr_en   = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    #3;
    check("drop_valid", {31'b0, inst_valid}, 32'h0);
    check("drop_mem_req", {31'b0, mem_req}, 32'h0);
    cycle(1, 0, 0, 1);
    #3;
    check("redir_addr", mem_addr, 32'h100);
    check("redir_req", {31'b0, mem_req}, 32'h1);
    budget = -1;
    repeat (15) cycle(1, 0, 0, 0);
    $display("jump: outstanding request discarded, redirect to 100");

    // --- jump in the same cycle as mem_done
    #3;
    check("pre_jump_req", {31'b0, mem_req}, 32'h1);
    cycle(1, 1, 32'h2003, 0);
    cycle(1, 0, 0, 0);
    #3;
    check("jd_valid", {31'b0, inst_valid}, 32'h0);
    check("jd_mem_req", {31'b0, mem_req}, 32'h0);
    cycle(1, 0, 0, 0);
    #3;
    check("jd_addr", mem_addr, 32'h2000);
    repeat (12) cycle(1, 0, 0, 0);
    $display("jump: same-cycle done dropped, redirect to 2000");

    // --- rdy low mid-stream, then reset mid-request
    lat_max = 1;
    repeat (8) cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0);
    repeat (8) cycle(1, 0, 0, 0);
    budget = 0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    #3;
    check("mid_wait_req", {31'b0, mem_req}, 32'h1);
    do_reset();
    lat_max = 0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    #3;
    check("post_rst_addr", mem_addr, RESET_PC);
    check("post_rst_req", {31'b0, mem_req}, 32'h1);
    $display("rdy/reset: freeze and async reset done");

    // --- randomized traffic
    lat_max = 3;
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(9, 0) != 0);
      j  = ($urandom_range(29, 0) == 0);
      st = ($urandom_range(2, 0) == 0);
      cycle(r, j, $urandom, st);
    end
    cycle(1, 0, 0, 0);
    #3;
    $display("random: %0d words delivered", delivered);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
